// File: rtl/multicycle_controller_pkg.sv
`default_nettype none
// ============================================================================
// Package  : multicycle_ctrl_pkg
// Purpose  : Shared types and encodings for the multicycle controller: FSM
//            state enum, RISC-V major opcodes, alu_op / wb_sel encodings and
//            the decoded-control bundle passed from ctrl_decode to the FSM.
// Revision : 1.0 - initial release
// ============================================================================
package multicycle_ctrl_pkg;

  // FSM states; encodings are visible on state_o for debug
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  // Supported major opcodes (instruction[6:0])
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // alu_op encodings
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_BCMP  = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_PASSB = 2'b11;

  // wb_sel encodings
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  // Decoded control for one opcode
  typedef struct packed {
    logic       valid;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic [1:0] wb_sel;
    logic       mem_to_reg;
  } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/multicycle_controller_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_decode
// Purpose  : Purely combinational opcode-to-control decode. Unsupported
//            opcodes return valid=0 so the FSM can trap them.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  output ctrl_t      ctrl_o
);

  // Map each major opcode to its ALU, operand and writeback controls
  always_comb begin
    ctrl_o         = '0;
    ctrl_o.alu_src = 1'b1;
    case (opcode_i)
      OPC_R: begin
        ctrl_o.valid   = 1'b1;
        ctrl_o.alu_op  = ALU_FUNCT;
        ctrl_o.alu_src = 1'b0;
        ctrl_o.wb_sel  = WB_ALU;
      end
      OPC_I_ALU: begin
        ctrl_o.valid  = 1'b1;
        ctrl_o.alu_op = ALU_FUNCT;
        ctrl_o.wb_sel = WB_ALU;
      end
      OPC_LOAD: begin
        ctrl_o.valid      = 1'b1;
        ctrl_o.alu_op     = ALU_ADD;
        ctrl_o.is_load    = 1'b1;
        ctrl_o.wb_sel     = WB_MEM;
        ctrl_o.mem_to_reg = 1'b1;
      end
      OPC_STORE: begin
        ctrl_o.valid    = 1'b1;
        ctrl_o.alu_op   = ALU_ADD;
        ctrl_o.is_store = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl_o.valid     = 1'b1;
        ctrl_o.alu_op    = ALU_BCMP;
        ctrl_o.alu_src   = 1'b0;
        ctrl_o.is_branch = 1'b1;
      end
      OPC_JAL: begin
        ctrl_o.valid  = 1'b1;
        ctrl_o.alu_op = ALU_ADD;
        ctrl_o.wb_sel = WB_PC4;
      end
      OPC_JALR: begin
        ctrl_o.valid  = 1'b1;
        ctrl_o.alu_op = ALU_ADD;
        ctrl_o.wb_sel = WB_PC4;
      end
      OPC_LUI: begin
        ctrl_o.valid  = 1'b1;
        ctrl_o.alu_op = ALU_PASSB;
        ctrl_o.wb_sel = WB_IMM;
      end
      OPC_AUIPC: begin
        ctrl_o.valid  = 1'b1;
        ctrl_o.alu_op = ALU_ADD;
        ctrl_o.wb_sel = WB_ALU;
      end
      default: begin
        ctrl_o.alu_src = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller
// Purpose  : FSM controller for a multicycle RISC-V style datapath
//            (FETCH, DECODE, EXEC, MEM, WB, HALT). Every control output is a
//            register, so strobes never follow ready inputs combinationally.
// Options  : IO_MAP_EN - when defined, accesses whose ALU-result high slice
//            equals IO_BASE_HIGH use the io_read/io_write strobes.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_controller
  import multicycle_ctrl_pkg::*;
#(
  parameter int                     ADDR_HIGH_W  = 22,
  parameter logic [ADDR_HIGH_W-1:0] IO_BASE_HIGH = '1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [6:0]             opcode,
  input  logic [ADDR_HIGH_W-1:0] alu_result_high,
  input  logic                   imem_ready,
  input  logic                   dmem_ready,
  output logic                   ir_write,
  output logic                   pc_write,
  output logic                   branch,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   io_read,
  output logic                   io_write,
  output logic                   mem_or_io_to_reg,
  output logic [1:0]             alu_op,
  output logic                   alu_src,
  output logic                   reg_write,
  output logic [1:0]             wb_sel,
  output logic                   illegal,
  output logic [2:0]             state_o
);

  state_e     state_q;
  logic [6:0] opcode_q;
  logic       ir_write_q, pc_write_q, branch_q;
  logic       mem_read_q, mem_write_q, io_read_q, io_write_q;
  logic       mem_or_io_to_reg_q, reg_write_q, alu_src_q, illegal_q;
  logic [1:0] alu_op_q, wb_sel_q;

  logic [6:0] w_dec_opcode;
  ctrl_t      w_ctrl;
  logic       w_is_io;

  // DECODE looks at the live IR opcode; afterwards the captured copy is used
  assign w_dec_opcode = (state_q == ST_DECODE) ? opcode : opcode_q;

  ctrl_decode u_ctrl_decode (
    .opcode_i (w_dec_opcode),
    .ctrl_o   (w_ctrl)
  );

`ifdef IO_MAP_EN
  assign w_is_io = (alu_result_high == IO_BASE_HIGH);
`else
  // Without the I/O map every access targets memory
  logic w_unused_io;
  assign w_unused_io = ^(alu_result_high ^ IO_BASE_HIGH);
  assign w_is_io     = 1'b0;
`endif

  // Single-process FSM: state plus every registered control output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= ST_FETCH;
      opcode_q           <= '0;
      ir_write_q         <= 1'b0;
      pc_write_q         <= 1'b0;
      branch_q           <= 1'b0;
      mem_read_q         <= 1'b0;
      mem_write_q        <= 1'b0;
      io_read_q          <= 1'b0;
      io_write_q         <= 1'b0;
      mem_or_io_to_reg_q <= 1'b0;
      reg_write_q        <= 1'b0;
      alu_op_q           <= 2'b00;
      alu_src_q          <= 1'b0;
      wb_sel_q           <= 2'b00;
      illegal_q          <= 1'b0;
    end else begin
      // Single-cycle pulses default low every cycle
      ir_write_q  <= 1'b0;
      pc_write_q  <= 1'b0;
      branch_q    <= 1'b0;
      reg_write_q <= 1'b0;
      case (state_q)
        ST_FETCH: begin
          if (imem_ready) begin
            ir_write_q <= 1'b1;
            pc_write_q <= 1'b1;
            state_q    <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          opcode_q <= opcode;
          if (w_ctrl.valid) begin
            alu_op_q  <= w_ctrl.alu_op;
            alu_src_q <= w_ctrl.alu_src;
            branch_q  <= w_ctrl.is_branch;
            state_q   <= ST_EXEC;
          end else begin
            illegal_q <= 1'b1;
            state_q   <= ST_HALT;
          end
        end
        ST_EXEC: begin
          if (w_ctrl.is_branch) begin
            alu_op_q  <= 2'b00;
            alu_src_q <= 1'b0;
            state_q   <= ST_FETCH;
          end else if (w_ctrl.is_load || w_ctrl.is_store) begin
            // Address is valid in EXEC, so the target space is chosen here
            mem_read_q  <= w_ctrl.is_load  && !w_is_io;
            mem_write_q <= w_ctrl.is_store && !w_is_io;
            io_read_q   <= w_ctrl.is_load  &&  w_is_io;
            io_write_q  <= w_ctrl.is_store &&  w_is_io;
            state_q     <= ST_MEM;
          end else begin
            reg_write_q        <= 1'b1;
            wb_sel_q           <= w_ctrl.wb_sel;
            mem_or_io_to_reg_q <= 1'b0;
            state_q            <= ST_WB;
          end
        end
        ST_MEM: begin
          if (dmem_ready) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            io_read_q   <= 1'b0;
            io_write_q  <= 1'b0;
            if (w_ctrl.is_load) begin
              reg_write_q        <= 1'b1;
              wb_sel_q           <= w_ctrl.wb_sel;
              mem_or_io_to_reg_q <= w_ctrl.mem_to_reg;
              state_q            <= ST_WB;
            end else begin
              alu_op_q  <= 2'b00;
              alu_src_q <= 1'b0;
              state_q   <= ST_FETCH;
            end
          end
        end
        ST_WB: begin
          wb_sel_q           <= 2'b00;
          mem_or_io_to_reg_q <= 1'b0;
          alu_op_q           <= 2'b00;
          alu_src_q          <= 1'b0;
          state_q            <= ST_FETCH;
        end
        ST_HALT: begin
          state_q <= ST_HALT;
        end
        default: begin
          state_q <= ST_FETCH;
        end
      endcase
    end
  end

  assign ir_write         = ir_write_q;
  assign pc_write         = pc_write_q;
  assign branch           = branch_q;
  assign mem_read         = mem_read_q;
  assign mem_write        = mem_write_q;
  assign io_read          = io_read_q;
  assign io_write         = io_write_q;
  assign mem_or_io_to_reg = mem_or_io_to_reg_q;
  assign alu_op           = alu_op_q;
  assign alu_src          = alu_src_q;
  assign reg_write        = reg_write_q;
  assign wb_sel           = wb_sel_q;
  assign illegal          = illegal_q;
  assign state_o          = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_controller
// Purpose  : Self-checking bench. A per-instruction reference model expands
//            each instruction into its expected cycle-by-cycle trace (states,
//            strobes, writeback controls) plus the ready inputs to drive.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

  localparam int             AW    = 22;
  localparam logic [AW-1:0]  IO_HI = '1;
`ifdef IO_MAP_EN
  localparam bit IO_EN = 1'b1;
`else
  localparam bit IO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [6:0]    opcode;
  logic [AW-1:0] alu_result_high;
  logic          imem_ready, dmem_ready;
  logic          ir_write, pc_write, branch, mem_read, mem_write;
  logic          io_read, io_write, mem_or_io_to_reg, alu_src, reg_write, illegal;
  logic [1:0]    alu_op, wb_sel;
  logic [2:0]    state_o;

  multicycle_controller #(.ADDR_HIGH_W(AW), .IO_BASE_HIGH(IO_HI)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .alu_result_high(alu_result_high),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .branch(branch),
    .mem_read(mem_read), .mem_write(mem_write), .io_read(io_read), .io_write(io_write),
    .mem_or_io_to_reg(mem_or_io_to_reg), .alu_op(alu_op), .alu_src(alu_src),
    .reg_write(reg_write), .wb_sel(wb_sel), .illegal(illegal), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    bit ir, pc, br, mr, mw, ior, iow, mtr, rw, ill;
    logic [1:0] wb;
    bit chk_aop, chk_src;
    logic [1:0] aop;
    bit src;
    bit imem, dmem, dec;
  } cyc_t;

  cyc_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic [14:0] w_obs;
  assign w_obs = {state_o, ir_write, pc_write, branch, mem_read, mem_write,
                  io_read, io_write, mem_or_io_to_reg, reg_write, wb_sel, illegal};

  function automatic logic [14:0] pack_exp(cyc_t r);
    return {r.st, r.ir, r.pc, r.br, r.mr, r.mw, r.ior, r.iow, r.mtr, r.rw, r.wb, r.ill};
  endfunction

  function automatic cyc_t mk(int st);
    cyc_t r;
    r.st = 3'(st); r.ir = 0; r.pc = 0; r.br = 0; r.mr = 0; r.mw = 0;
    r.ior = 0; r.iow = 0; r.mtr = 0; r.rw = 0; r.ill = 0; r.wb = 2'b00;
    r.chk_aop = 0; r.chk_src = 0; r.aop = 2'b00; r.src = 0;
    r.imem = 1'($urandom_range(0, 1)); r.dmem = 1'($urandom_range(0, 1)); r.dec = 0;
    return r;
  endfunction

  task automatic check(input string tag, input logic [14:0] obs, input logic [14:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Expand one instruction into its expected trace (states: 0 FETCH, 1 DECODE,
  // 2 EXEC, 3 MEM, 4 WB, 5 HALT). Returns whether the instruction traps.
  task automatic model(input logic [6:0] op, input logic [AW-1:0] a, input int fw,
                       input int mw, input int halt_cyc, output bit halted);
    cyc_t r;
    bit legal = 1, has_aop = 1, ld = 0, st = 0, br = 0, src = 1, mtr = 0;
    logic [1:0] aop = 2'b00, wb = 2'b00;
    bit io;
    case (op)
      7'b0110011: begin aop = 2'b10; src = 0; end
      7'b0010011: aop = 2'b10;
      7'b0000011: begin ld = 1; wb = 2'b01; mtr = 1; end
      7'b0100011: st = 1;
      7'b1100011: begin br = 1; aop = 2'b01; src = 0; end
      7'b1101111: begin has_aop = 0; wb = 2'b10; end
      7'b1100111: wb = 2'b10;
      7'b0110111: begin aop = 2'b11; wb = 2'b11; end
      7'b0010111: ;
      default: legal = 0;
    endcase
    io = IO_EN && (a == IO_HI);
    for (int k = 0; k <= fw; k++) begin
      r = mk(0); r.imem = (k == fw); exp_q.push_back(r);
    end
    r = mk(1); r.ir = 1; r.pc = 1; r.dec = 1; exp_q.push_back(r);
    halted = !legal;
    if (!legal) begin
      for (int k = 0; k < halt_cyc; k++) begin
        r = mk(5); r.ill = 1; r.imem = k[0]; exp_q.push_back(r);
      end
      return;
    end
    r = mk(2); r.br = br; r.chk_aop = has_aop; r.aop = aop; r.chk_src = 1; r.src = src;
    exp_q.push_back(r);
    if (ld || st) begin
      for (int k = 0; k <= mw; k++) begin
        r = mk(3); r.dmem = (k == mw);
        r.mr = ld && !io; r.ior = ld && io; r.mw = st && !io; r.iow = st && io;
        exp_q.push_back(r);
      end
    end
    if (!br && !st) begin
      r = mk(4); r.rw = 1; r.wb = wb; r.mtr = mtr; exp_q.push_back(r);
    end
  endtask

  // Play up to lim expected cycles: check outputs, then drive that cycle's inputs
  task automatic play(input logic [6:0] op, input logic [AW-1:0] a, input int lim);
    cyc_t r;
    int n = 0;
    while (exp_q.size() > 0 && n < lim) begin
      r = exp_q.pop_front();
      @(negedge clk);
      check($sformatf("trace op=%b st=%0d", op, r.st), w_obs, pack_exp(r));
      if (r.chk_aop) check($sformatf("alu_op op=%b", op), {13'd0, alu_op}, {13'd0, r.aop});
      if (r.chk_src) check($sformatf("alu_src op=%b", op), {14'd0, alu_src}, {14'd0, r.src});
      opcode          = r.dec ? op : 7'($urandom);
      imem_ready      = r.imem;
      dmem_ready      = r.dmem;
      alu_result_high = a;
      n++;
    end
  endtask

  task automatic run(input logic [6:0] op, input logic [AW-1:0] a, input int fw,
                     input int mw, output bit halted);
    model(op, a, fw, mw, 6, halted);
    play(op, a, 1000);
  endtask

  task automatic do_reset();
    @(negedge clk);
    imem_ready = 0; dmem_ready = 0;
    rst_n = 0;
    #1 check("reset_state", w_obs, 15'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1;
  endtask

  logic [6:0] legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                7'b0010111};

  initial begin
    bit h;
    logic [6:0] op;
    logic [AW-1:0] a;
    cyc_t r;
    rst_n = 0; opcode = 0; alu_result_high = 0; imem_ready = 0; dmem_ready = 0;
    repeat (2) @(negedge clk);
    check("reset_outputs", w_obs, 15'd0);
    rst_n = 1;

    // Directed: ADD, LW with 3 wait cycles, SW to I/O address, BEQ
    run(7'b0110011, 22'h000123, 0, 0, h);
    run(7'b0000011, 22'h000456, 0, 3, h);
    run(7'b0100011, 22'h3FFFFF, 0, 0, h);
    run(7'b1100011, 22'h000000, 0, 0, h);
    run(7'b0110111, 22'h000000, 1, 0, h);
    run(7'b0000011, 22'h3FFFFF, 2, 1, h);

    // Illegal opcode: HALT with imem_ready pulses, then reset clears illegal
    run(7'b1111111, 22'h0, 0, 0, h);
    do_reset();

    // Reset during a MEM wait: strobe must drop at once
    model(7'b0000011, 22'h000010, 0, 20, 0, h);
    play(7'b0000011, 22'h000010, 5);
    @(posedge clk);
    #2;
    r = mk(3); r.mr = 1;
    check("mem_wait_before_reset", w_obs, pack_exp(r));
    rst_n = 0;
    #1 check("async_reset_drop", w_obs, 15'd0);
    exp_q.delete();
    imem_ready = 0; dmem_ready = 0;
    @(negedge clk);
    rst_n = 1;
    run(7'b0110011, 22'h0, 0, 0, h);

    // Randomized instruction stream
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 11) == 0) op = 7'($urandom);
      else op = legal_ops[$urandom_range(0, 8)];
      a = ($urandom_range(0, 1) == 1) ? IO_HI : AW'($urandom);
      run(op, a, $urandom_range(0, 2), $urandom_range(0, 3), h);
      if (h) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
